led_scan_ctrl: RTL and testbench

Sequencer for the board's four-digit seven-segment debug display and the single-step button. It generates the digit-scan schedule with inter-digit blanking. It selects which debug page (PC, RS, RT, ALU/DB) is shown and only changes page on frame boundaries. It also debounces the step button into a one-cycle CPU step pulse. It sits between the board I/O and the display-decode and CPU clock-enable logic.

---
 rtl/led_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_led_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// Seven-segment digit scan sequencer with frame-aligned page select and step-button debounce.
// Optional build macro LED_AUTO_PAGE_EN adds automatic page cycling driven by Auto_Mode.
module led_scan_ctrl #(
  parameter int CLK_DIV         = 50000,
  parameter int BLANK_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_FRAMES     = 64
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] Switch_Status,
  input  logic       Step_Button,
  input  logic       Auto_Mode,
  output logic [1:0] Digit_Sel,
  output logic [1:0] Page_Sel,
  output logic       Blank,
  output logic       Scan_Tick,
  output logic       Step_Pulse
);

  localparam int SCAN_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int SCAN_W   = $clog2(SCAN_MAX);
  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [SCAN_W-1:0] SHOW_PRE   = SCAN_W'(CLK_DIV - 2);
  localparam logic [SCAN_W-1:0] SHOW_LAST  = SCAN_W'(CLK_DIV - 1);
  localparam logic [SCAN_W-1:0] BLANK_LAST = SCAN_W'(BLANK_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_SHOW, ST_BLANK} scan_state_t;

  scan_state_t       state;
  logic [SCAN_W-1:0] scan_cnt;
  logic              frame_end;

  logic [1:0]        sw_p0, sw_p1;
  logic              btn_p0, btn_p1;
  logic              deb_level;
  logic [DEB_W-1:0]  deb_cnt;

  // Last blanking cycle of digit 3: the edge on which Digit_Sel wraps to 0.
  assign frame_end = (state == ST_BLANK) && (scan_cnt == BLANK_LAST) && (Digit_Sel == 2'd3);

  // Scan FSM; Scan_Tick is decoded one count early so the registered pulse
  // lands in the last SHOW cycle.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= ST_SHOW;
      scan_cnt  <= '0;
      Digit_Sel <= 2'd0;
      Blank     <= 1'b0;
      Scan_Tick <= 1'b0;
    end else begin
      case (state)
        ST_SHOW: begin
          Scan_Tick <= (scan_cnt == SHOW_PRE);
          if (scan_cnt == SHOW_LAST) begin
            scan_cnt <= '0;
            state    <= ST_BLANK;
            Blank    <= 1'b1;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          Scan_Tick <= 1'b0;
          if (scan_cnt == BLANK_LAST) begin
            scan_cnt  <= '0;
            state     <= ST_SHOW;
            Blank     <= 1'b0;
            Digit_Sel <= Digit_Sel + 2'd1;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        default: state <= ST_SHOW;
      endcase
    end
  end

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      btn_p0     <= 1'b0;
      btn_p1     <= 1'b0;
      deb_level  <= 1'b0;
      deb_cnt    <= '0;
      Step_Pulse <= 1'b0;
    end else begin
      btn_p0     <= Step_Button;
      btn_p1     <= btn_p0;
      Step_Pulse <= 1'b0;
      if (btn_p1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level  <= btn_p1;
        deb_cnt    <= '0;
        Step_Pulse <= btn_p1;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

`ifdef LED_AUTO_PAGE_EN
  localparam int FRM_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(AUTO_FRAMES - 1);

  logic             auto_p0, auto_p1;
  logic [FRM_W-1:0] frame_cnt;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      sw_p0     <= 2'b00;
      sw_p1     <= 2'b00;
      auto_p0   <= 1'b0;
      auto_p1   <= 1'b0;
      frame_cnt <= '0;
      Page_Sel  <= 2'b00;
    end else begin
      sw_p0   <= Switch_Status;
      sw_p1   <= sw_p0;
      auto_p0 <= Auto_Mode;
      auto_p1 <= auto_p0;
      if (!auto_p1) begin
        frame_cnt <= '0;
      end
      if (frame_end) begin
        if (auto_p1) begin
          if (frame_cnt == FRM_LAST) begin
            frame_cnt <= '0;
            Page_Sel  <= Page_Sel + 2'd1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          Page_Sel <= sw_p1;
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = Auto_Mode ^ (AUTO_FRAMES == 0);

  // Page only moves on the frame boundary so one frame never mixes pages.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      sw_p0    <= 2'b00;
      sw_p1    <= 2'b00;
      Page_Sel <= 2'b00;
    end else begin
      sw_p0 <= Switch_Status;
      sw_p1 <= sw_p0;
      if (frame_end) begin
        Page_Sel <= sw_p1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: stimulus queues expected per-cycle outputs, a monitor checks them.
module tb_led_scan_ctrl;
  localparam int CLK_DIV         = 4;
  localparam int BLANK_CYCLES    = 2;
  localparam int DEBOUNCE_CYCLES = 3;
  localparam int AUTO_FRAMES     = 2;
  localparam int PERIOD          = CLK_DIV + BLANK_CYCLES;
  localparam int FRAME           = 4 * PERIOD;
  localparam int BASE1           = 2;
  localparam int RST_REL         = 137;
  localparam int BASE2           = BASE1 + RST_REL;
  localparam int C_LEN           = 200;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] Switch_Status = 2'b00;
  logic       Step_Button = 1'b0;
  logic       Auto_Mode = 1'b0;
  logic [1:0] Digit_Sel;
  logic [1:0] Page_Sel;
  logic       Blank;
  logic       Scan_Tick;
  logic       Step_Pulse;

  led_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .AUTO_FRAMES(AUTO_FRAMES)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Switch_Status(Switch_Status), .Step_Button(Step_Button),
    .Auto_Mode(Auto_Mode), .Digit_Sel(Digit_Sel), .Page_Sel(Page_Sel), .Blank(Blank),
    .Scan_Tick(Scan_Tick), .Step_Pulse(Step_Pulse)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] dig;
    logic       blank;
    logic       tick;
    logic [1:0] page;
    logic       pulse;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, string f, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s cycle %0d: got %0d, expected %0d", tag, f, cyc, act, exp);
    end
  endtask

  // Scan outputs from the closed-form schedule: rel cycle 1 is the first cycle after reset.
  function automatic exp_t scan_exp(int abs_c, int rel, logic [1:0] page, logic pulse, string tag);
    exp_t e;
    int d;
    d = (rel - 1) % PERIOD;
    e.cyc   = abs_c;
    e.dig   = 2'(((rel - 1) / PERIOD) % 4);
    e.blank = (d >= CLK_DIV);
    e.tick  = (d == CLK_DIV - 1);
    e.page  = page;
    e.pulse = pulse;
    e.tag   = tag;
    return e;
  endfunction

  function automatic logic [1:0] page_a(int rel);
    if (rel <= 3 * FRAME) return 2'b00;
    if (rel <= 5 * FRAME) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [1:0] page_c(int rel);
`ifdef LED_AUTO_PAGE_EN
    return 2'(((rel - 1) / (AUTO_FRAMES * FRAME)) % 4);
`else
    return (rel <= FRAME) ? 2'b00 : 2'b11;
`endif
  endfunction

  function automatic string tag_a(int rel);
    if (rel <= 24) return "scan";
    if (rel <= 48) return "glitch";
    if (rel <= 78) return "midchg";
    if (rel <= 110) return "button";
    return "pre_reset";
  endfunction

  function automatic int abs_a(int rel);
    return BASE1 + rel - 1;
  endfunction

  task automatic wait_abs(int a);
    while (cyc < a) @(negedge CLK);
  endtask

  // Monitor: pops the entry for the current cycle and compares every output.
  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_%s: now cycle %0d, required cycle %0d", e.tag, cyc, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk(e.tag, "Digit_Sel", int'(Digit_Sel), int'(e.dig));
      chk(e.tag, "Blank", int'(Blank), int'(e.blank));
      chk(e.tag, "Scan_Tick", int'(Scan_Tick), int'(e.tick));
      chk(e.tag, "Page_Sel", int'(Page_Sel), int'(e.page));
      chk(e.tag, "Step_Pulse", int'(Step_Pulse), int'(e.pulse));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, required finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t r;
    r.cyc = 1; r.dig = 2'd0; r.blank = 1'b0; r.tick = 1'b0;
    r.page = 2'b00; r.pulse = 1'b0; r.tag = "reset";
    sb.push_back(r);
    for (int k = 1; k <= RST_REL; k++)
      sb.push_back(scan_exp(abs_a(k), k, page_a(k), (k == 89), tag_a(k)));
    for (int k = 1; k <= C_LEN; k++)
      sb.push_back(scan_exp(BASE2 + k - 1, k, page_c(k), 1'b0, (k == 1) ? "mid_reset" : "auto"));

    wait_abs(BASE1);
    Reset = 1'b1;
    wait_abs(abs_a(28));  Switch_Status = 2'b11;
    wait_abs(abs_a(32));  Switch_Status = 2'b00;
    wait_abs(abs_a(55));  Switch_Status = 2'b10;
    wait_abs(abs_a(80));  Step_Button = 1'b1;
    wait_abs(abs_a(81));  Step_Button = 1'b0;
    wait_abs(abs_a(82));  Step_Button = 1'b1;
    wait_abs(abs_a(83));  Step_Button = 1'b0;
    wait_abs(abs_a(84));  Step_Button = 1'b1;
    wait_abs(abs_a(94));  Step_Button = 1'b0;
    wait_abs(abs_a(100)); Switch_Status = 2'b01;
    wait_abs(abs_a(RST_REL)); Reset = 1'b0;
    wait_abs(BASE2);
    Reset = 1'b1;
    Auto_Mode = 1'b1;
    Switch_Status = 2'b11;
    wait_abs(BASE2 + C_LEN + 1);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_entries: got %0d unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
